// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - cycle, retire and event performance counters with freeze on halt
//
// Counts run cycles, retired instructions and NUM_EVENTS event strobes while the
// block is in RUN and holds them once the processor halts. Any counter can be read
// through a registered select port.
//
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous active-low reset
//   start    leave IDLE and begin counting
//   clear    synchronous clear of counters, flags and state
//   retire   one instruction retired this cycle
//   halt     processor halt reached the memory stage
//   evt      per-channel event strobes
//   rd_sel   counter select: 0 cycles, 1 retired, 2+k event k
//   rd_data  registered value of the selected counter
//   ovf      sticky overflow flags, indexed like rd_sel
//   running  block is counting
//   frozen   block has stopped on halt
module perf_counter_bank #(
  parameter int NUM_EVENTS = 4,
  parameter int CNT_WIDTH  = 32,
  parameter bit SATURATE   = 1'b0,
  localparam int SEL_W     = $clog2(NUM_EVENTS + 2)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    clear,
  input  logic                    retire,
  input  logic                    halt,
  input  logic [NUM_EVENTS-1:0]   evt,
  input  logic [SEL_W-1:0]        rd_sel,
  output logic [CNT_WIDTH-1:0]    rd_data,
  output logic [NUM_EVENTS+1:0]   ovf,
  output logic                    running,
  output logic                    frozen
);

  localparam int NUM_CNT = NUM_EVENTS + 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } stateE;

  stateE                 state;
  logic [CNT_WIDTH-1:0]  cnt     [NUM_CNT];
  logic [CNT_WIDTH-1:0]  cntNext [NUM_CNT];
  logic [NUM_CNT-1:0]    incReq;
  logic [NUM_CNT-1:0]    ovfNext;
  logic [CNT_WIDTH-1:0]  rdNext;

  // Increment requests share the rd_sel index map: bit 0 is the cycle counter,
  // bit 1 the retire counter, bits 2.. the event channels. The halt cycle itself
  // is still in RUN, so it is counted in full.
  always_comb begin
    incReq  = (state == RUN) ? {evt, retire, 1'b1} : '0;
    ovfNext = ovf;
    for (int i = 0; i < NUM_CNT; i++) begin
      cntNext[i] = cnt[i];
      if (incReq[i]) begin
        if (&cnt[i]) begin
          ovfNext[i] = 1'b1;
          if (!SATURATE) begin
            cntNext[i] = '0;
          end
        end else begin
          cntNext[i] = cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Read mux works on post-update values so rd_data includes this edge's increment.
  // Selects past the last counter fall through to 0.
  always_comb begin
    rdNext = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rdNext = cntNext[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      running <= 1'b0;
      frozen  <= 1'b0;
      ovf     <= '0;
      rd_data <= '0;
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt[i] <= '0;
      end
    end else if (clear) begin
      state   <= IDLE;
      running <= 1'b0;
      frozen  <= 1'b0;
      ovf     <= '0;
      rd_data <= '0;
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt[i] <= cntNext[i];
      end
      ovf     <= ovfNext;
      rd_data <= rdNext;
      case (state)
        IDLE: begin
          // start wins over a simultaneous halt, which has no meaning in IDLE
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (halt) begin
            state   <= FROZEN;
            running <= 1'b0;
            frozen  <= 1'b1;
          end
        end
        FROZEN: begin
          state <= FROZEN;
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          frozen  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - directed self-checking bench for perf_counter_bank
module tb_perf_counter_bank;

  logic        clk;
  logic        rst;
  logic        start;
  logic        clear;
  logic        retire;
  logic        halt;
  logic [3:0]  evt;
  logic [2:0]  rdSel;

  logic [31:0] rdMain;
  logic [7:0]  rdWrap;
  logic [7:0]  rdSat;
  logic [5:0]  ovfMain, ovfWrap, ovfSat;
  logic        runMain, runWrap, runSat;
  logic        frzMain, frzWrap, frzSat;

  int nVec;
  int nErr;

  perf_counter_bank uMain (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .retire(retire),
    .halt(halt), .evt(evt), .rd_sel(rdSel), .rd_data(rdMain), .ovf(ovfMain),
    .running(runMain), .frozen(frzMain)
  );

  perf_counter_bank #(.NUM_EVENTS(4), .CNT_WIDTH(8), .SATURATE(1'b0)) uWrap (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .retire(retire),
    .halt(halt), .evt(evt), .rd_sel(rdSel), .rd_data(rdWrap), .ovf(ovfWrap),
    .running(runWrap), .frozen(frzWrap)
  );

  perf_counter_bank #(.NUM_EVENTS(4), .CNT_WIDTH(8), .SATURATE(1'b1)) uSat (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .retire(retire),
    .halt(halt), .evt(evt), .rd_sel(rdSel), .rd_data(rdSat), .ovf(ovfSat),
    .running(runSat), .frozen(frzSat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; clear = 1'b0; retire = 1'b0; halt = 1'b0;
    evt = 4'h0; rdSel = 3'd0;
    #2 rst = 1'b0;
    #1;
    nVec++;
    if ({rdMain, rdWrap, rdSat} !== 48'd0) begin
      nErr++; $display("FAIL reset_rd_data: got %h expected 0", {rdMain, rdWrap, rdSat});
    end
    nVec++;
    if ({ovfMain, ovfWrap, ovfSat, runMain, runWrap, runSat, frzMain, frzWrap, frzSat} !== 24'd0) begin
      nErr++; $display("FAIL reset_flags: got %h expected 0",
        {ovfMain, ovfWrap, ovfSat, runMain, runWrap, runSat, frzMain, frzWrap, frzSat});
    end
    #5 rst = 1'b1;
    step();
    evt = 4'hF; retire = 1'b1;
    repeat (10) step();
    for (int i = 0; i < 6; i++) begin
      rdSel = 3'(i);
      step();
      nVec++;
      if ({rdMain, rdWrap, rdSat} !== 48'd0) begin
        nErr++; $display("FAIL idle_read_sel%0d: got %h expected 0", i, {rdMain, rdWrap, rdSat});
      end
    end
    nVec++;
    if ({ovfMain, ovfWrap, ovfSat, runMain, runWrap, runSat} !== 21'd0) begin
      nErr++; $display("FAIL idle_flags: got %h expected 0",
        {ovfMain, ovfWrap, ovfSat, runMain, runWrap, runSat});
    end
  endtask

  task automatic test_basic_count();
    evt = 4'h0; retire = 1'b0; rdSel = 3'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    nVec++;
    if ({runMain, runWrap, runSat} !== 3'b111) begin
      nErr++; $display("FAIL start_running: got %b expected 111", {runMain, runWrap, runSat});
    end
    for (int i = 0; i < 20; i++) begin
      retire = (i < 12);
      evt    = (i < 5) ? 4'b0001 : 4'b0000;
      step();
    end
    halt = 1'b1; retire = 1'b1; evt = 4'h0;
    step();
    nVec++;
    if ({frzMain, frzWrap, frzSat, runMain, runWrap, runSat} !== 6'b111000) begin
      nErr++; $display("FAIL halt_frozen: got %b expected 111000",
        {frzMain, frzWrap, frzSat, runMain, runWrap, runSat});
    end
    halt = 1'b0; retire = 1'b1; evt = 4'hF;
    rdSel = 3'd0; step();
    nVec++;
    if ({rdMain, rdWrap, rdSat} !== {32'd21, 8'd21, 8'd21}) begin
      nErr++; $display("FAIL basic_cycles: got %h expected 21", {rdMain, rdWrap, rdSat});
    end
    rdSel = 3'd1; step();
    nVec++;
    if ({rdMain, rdWrap, rdSat} !== {32'd13, 8'd13, 8'd13}) begin
      nErr++; $display("FAIL basic_retired: got %h expected 13", {rdMain, rdWrap, rdSat});
    end
    rdSel = 3'd2; step();
    nVec++;
    if ({rdMain, rdWrap, rdSat} !== {32'd5, 8'd5, 8'd5}) begin
      nErr++; $display("FAIL basic_evt0: got %h expected 5", {rdMain, rdWrap, rdSat});
    end
    rdSel = 3'd3; step();
    nVec++;
    if ({rdMain, rdWrap, rdSat} !== 48'd0) begin
      nErr++; $display("FAIL basic_evt1: got %h expected 0", {rdMain, rdWrap, rdSat});
    end
    repeat (10) step();
    rdSel = 3'd0; step();
    nVec++;
    if ({rdMain, rdWrap, rdSat} !== {32'd21, 8'd21, 8'd21}) begin
      nErr++; $display("FAIL frozen_hold: got %h expected 21", {rdMain, rdWrap, rdSat});
    end
    nVec++;
    if ({ovfMain, ovfWrap, ovfSat} !== 18'd0) begin
      nErr++; $display("FAIL basic_ovf: got %h expected 0", {ovfMain, ovfWrap, ovfSat});
    end
  endtask

  task automatic test_wrap_saturate();
    evt = 4'h0; retire = 1'b0;
    clear = 1'b1; step(); clear = 1'b0;
    nVec++;
    if ({rdMain, rdWrap, rdSat, frzMain, frzWrap, frzSat, runMain, runWrap, runSat} !== 54'd0) begin
      nErr++; $display("FAIL clear_from_frozen: got %h expected 0",
        {rdMain, rdWrap, rdSat, frzMain, frzWrap, frzSat, runMain, runWrap, runSat});
    end
    rdSel = 3'd3; start = 1'b1; step(); start = 1'b0;
    evt = 4'b0010;
    repeat (257) step();
    nVec++;
    if ({rdMain, rdWrap, rdSat} !== {32'd257, 8'd1, 8'hFF}) begin
      nErr++; $display("FAIL wrap_sat_evt1: got %h expected %h", {rdMain, rdWrap, rdSat},
        {32'd257, 8'd1, 8'hFF});
    end
    nVec++;
    if ({ovfMain, ovfWrap, ovfSat} !== {6'b000000, 6'b001001, 6'b001001}) begin
      nErr++; $display("FAIL wrap_sat_ovf: got %b expected 000000001001001001",
        {ovfMain, ovfWrap, ovfSat});
    end
    repeat (5) step();
    nVec++;
    if ({rdMain, rdWrap, rdSat} !== {32'd262, 8'd6, 8'hFF}) begin
      nErr++; $display("FAIL sat_hold_evt1: got %h expected %h", {rdMain, rdWrap, rdSat},
        {32'd262, 8'd6, 8'hFF});
    end
    rdSel = 3'd0; step();
    nVec++;
    if ({rdMain, rdWrap, rdSat} !== {32'd263, 8'd7, 8'hFF}) begin
      nErr++; $display("FAIL wrap_sat_cycles: got %h expected %h", {rdMain, rdWrap, rdSat},
        {32'd263, 8'd7, 8'hFF});
    end
  endtask

  task automatic test_clear_priority();
    clear = 1'b1; halt = 1'b1; evt = 4'hF; retire = 1'b1; rdSel = 3'd0;
    step();
    clear = 1'b0; halt = 1'b0; evt = 4'h0; retire = 1'b0;
    nVec++;
    if ({runMain, runWrap, runSat, frzMain, frzWrap, frzSat} !== 6'd0) begin
      nErr++; $display("FAIL clear_state: got %b expected 000000",
        {runMain, runWrap, runSat, frzMain, frzWrap, frzSat});
    end
    nVec++;
    if ({rdMain, rdWrap, rdSat, ovfMain, ovfWrap, ovfSat} !== 66'd0) begin
      nErr++; $display("FAIL clear_values: got %h expected 0",
        {rdMain, rdWrap, rdSat, ovfMain, ovfWrap, ovfSat});
    end
    repeat (2) step();
    start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    nVec++;
    if ({rdMain, rdWrap, rdSat} !== {32'd3, 8'd3, 8'd3}) begin
      nErr++; $display("FAIL restart_count: got %h expected 3", {rdMain, rdWrap, rdSat});
    end
  endtask

  task automatic test_start_halt_same_cycle();
    clear = 1'b1; step(); clear = 1'b0;
    start = 1'b1; halt = 1'b1; rdSel = 3'd0;
    step();
    start = 1'b0;
    nVec++;
    if ({runMain, frzMain, rdMain} !== {1'b1, 1'b0, 32'd0}) begin
      nErr++; $display("FAIL start_beats_halt: got %h expected %h",
        {runMain, frzMain, rdMain}, {1'b1, 1'b0, 32'd0});
    end
    step();
    halt = 1'b0;
    nVec++;
    if ({runMain, frzMain, rdMain} !== {1'b0, 1'b1, 32'd1}) begin
      nErr++; $display("FAIL halt_first_cycle: got %h expected %h",
        {runMain, frzMain, rdMain}, {1'b0, 1'b1, 32'd1});
    end
  endtask

  task automatic test_async_reset_read();
    clear = 1'b1; step(); clear = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    evt = 4'hF; retire = 1'b1;
    repeat (3) step();
    rdSel = 3'd2; step();
    nVec++;
    if ({rdMain, rdWrap, rdSat} !== {32'd4, 8'd4, 8'd4}) begin
      nErr++; $display("FAIL pre_reset_evt0: got %h expected 4", {rdMain, rdWrap, rdSat});
    end
    #2 rst = 1'b0;
    #1;
    nVec++;
    if ({rdMain, rdWrap, rdSat, runMain, runWrap, runSat} !== 51'd0) begin
      nErr++; $display("FAIL async_reset: got %h expected 0",
        {rdMain, rdWrap, rdSat, runMain, runWrap, runSat});
    end
    #2 rst = 1'b1;
    repeat (3) step();
    nVec++;
    if ({rdMain, runMain} !== 33'd0) begin
      nErr++; $display("FAIL post_reset_idle: got %h expected 0", {rdMain, runMain});
    end
    rdSel = 3'd0; step();
    nVec++;
    if ({rdMain, rdWrap, rdSat} !== 48'd0) begin
      nErr++; $display("FAIL post_reset_cycles: got %h expected 0", {rdMain, rdWrap, rdSat});
    end
    start = 1'b1; step(); start = 1'b0;
    repeat (4) step();
    halt = 1'b1; step(); halt = 1'b0;
    rdSel = 3'd6; step();
    nVec++;
    if ({rdMain, rdWrap, rdSat} !== 48'd0) begin
      nErr++; $display("FAIL out_of_range_sel: got %h expected 0", {rdMain, rdWrap, rdSat});
    end
    rdSel = 3'd0;
    #3;
    nVec++;
    if (rdMain !== 32'd0) begin
      nErr++; $display("FAIL read_latency_before_edge: got %0d expected 0", rdMain);
    end
    step();
    nVec++;
    if ({rdMain, rdWrap, rdSat} !== {32'd5, 8'd5, 8'd5}) begin
      nErr++; $display("FAIL read_latency_after_edge: got %h expected 5", {rdMain, rdWrap, rdSat});
    end
    rdSel = 3'd5; step();
    nVec++;
    if (rdMain !== 32'd5) begin
      nErr++; $display("FAIL read_evt3: got %0d expected 5", rdMain);
    end
    evt = 4'h0; retire = 1'b0;
  endtask

  initial begin
    nVec = 0;
    nErr = 0;
    test_reset();
    test_basic_count();
    test_wrap_saturate();
    test_clear_priority();
    test_start_halt_same_cycle();
    test_async_reset_read();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Synthesizable performance-monitor block for the pipelined processor. It counts cycles, retired instructions and NUM_EVENTS generic event strobes (e.g. I/D cache requests and hits) while running, and freezes all counts when the processor halts. Counts are read back through a registered select port. It sits beside the core in `proc_hier`, fed by pipeline-stage strobes, and replaces free-running bench-side integer counters with hardware counters that the bench and the software can both read.

## Interface
- NUM_EVENTS, 4, number of generic event channels (1..14).
- CNT_WIDTH, 32, width of every counter (8..48).
- SATURATE, 0, overflow mode: 0 = wrap to 0, 1 = hold at all-ones.
- SEL_W, derived = $clog2(NUM_EVENTS+2), read-select width; not overridden.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begins counting; honoured only in IDLE.
- clear  in  1  synchronous clear of all counters, flags and state.
- retire  in  1  one instruction retired this cycle (integrator ORs reg-write, mem-write and halt).
- halt  in  1  processor halt reached the memory stage this cycle.
- evt  in  NUM_EVENTS  per-channel event strobes, one count per high cycle.
- rd_sel  in  SEL_W  counter select: 0 = cycles, 1 = retired, 2+k = event k.
- rd_data  out  CNT_WIDTH  registered value of the selected counter.
- ovf  out  NUM_EVENTS+2  sticky overflow flags, same index map as rd_sel.
- running  out  1  state is RUN.
- frozen  out  1  state is FROZEN.

## Operation
- Three states:
  - IDLE: the reset state; no counting.
  - RUN.
  - FROZEN.
- Transitions:
  - IDLE -> RUN when start=1.
  - RUN -> FROZEN when halt=1.
  - FROZEN holds until clear.
  - clear=1 in any state -> IDLE.
- In RUN, every cycle:
  - cycle counter +1.
  - retired counter +1 if retire.
  - event counter k +1 if evt[k].
- The cycle in which halt=1 in RUN is counted in full, including its retire and evt strobes. Counting stops from the next cycle.
- IDLE and FROZEN: counters hold. retire, evt and halt are ignored. start is ignored in FROZEN and RUN.
- Overflow on an increment from all-ones:
  - SATURATE=0: the counter wraps to 0.
  - SATURATE=1: the counter stays at all-ones.
  - In both modes the matching ovf bit sets and stays set until clear or reset.
- clear priority: clear beats start, halt and all increments in the same cycle. Counters, ovf and rd_data go to 0 and the state goes to IDLE.
- Read:
  - rd_data is updated every cycle from the post-update counter value of the counter selected by rd_sel.
  - An out-of-range rd_sel (> NUM_EVENTS+1) returns 0.
- All arithmetic is unsigned, CNT_WIDTH bits. There is no carry between counters.

## Timing
- Reset (rst=0, asynchronous): state IDLE; all counters 0; ovf=0; rd_data=0; running=0; frozen=0.
- Reset mid-RUN takes effect immediately, without waiting for a clock edge. After release, the block stays in IDLE until start.
- start sampled at edge N: running=1 after edge N. The first counted cycle is edge N+1.
- Increment latency: a strobe sampled at edge N is visible in the counter after edge N.
- Read latency is 1 cycle: with rd_sel stable, rd_data after edge N reflects the counter including the increment made at edge N.
- halt sampled at edge N in RUN: frozen=1 and running=0 after edge N. The counts include cycle N.
- halt and start in the same IDLE cycle: start is honoured and halt is ignored. The block is in RUN next cycle.
- ovf[i] rises at the same edge as the overflowing increment.

## Test plan
- Reset/idle:
  - Stimulus: rst low then high; evt=all-ones and retire=1 for 10 cycles without start.
  - Required: every rd_sel reads 0, ovf=0, running=0.
- Basic count:
  - Stimulus: start, then 20 RUN cycles with retire high on 12 of them and evt[0] high on 5, then halt on the 21st cycle with retire=1.
  - Required: cycles=21, retired=13, evt0=5; frozen=1; the counts do not change over the next 10 cycles.
- Wrap mode:
  - Stimulus: CNT_WIDTH=8, SATURATE=0; 257 cycles with evt[1]=1.
  - Required: evt1 counter reads 1, ovf[3]=1, cycle counter reads 1, ovf[0]=1.
- Saturate mode:
  - Stimulus: CNT_WIDTH=8, SATURATE=1; same stimulus as wrap mode.
  - Required: evt1 reads 0xFF, ovf[3]=1, and it stays 0xFF on further events.
- Clear priority:
  - Stimulus: in RUN, assert clear together with halt and evt all-ones.
  - Required: next cycle state IDLE, all counters 0, ovf=0, frozen=0. A new start restarts counting from 0.
- Async reset mid-run plus read:
  - Stimulus: counters nonzero; rst dropped between edges.
  - Required: rd_data and counters reach 0 before the next edge. Also rd_sel=NUM_EVENTS+2 -> rd_data=0, and a change of rd_sel appears on rd_data exactly one edge later.
